rb_serializer: RTL and testbench
================================

RB_SERIALIZER -- requirements
Module: rb_serializer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous active-low reset, sampled on rising clk; rst=0 resets, rst=1 runs.
REQ-003 RB1_RW  output  1  register-bank read/write select; 1 = read.
REQ-004 RB1_A  output  3  register-bank word address.
REQ-005 RB1_Q  input  18  register-bank read data, valid the cycle after RB1_A is presented.
REQ-006 sen  output  1  serial enable; 1 during every packet bit.
REQ-007 sd  output  1  serial data bit.
REQ-008 S1_done  output  1  high once all 8 packets are sent.

Function
REQ-009 Block SHALL read all 8 words of RB1 and send each as one 21-bit packet: 3-bit address MSB first, then 18-bit data MSB first (bit17..bit0).
REQ-010 RB1_RW SHALL be 1 in every cycle, including reset; no writes are issued.
REQ-011 States SHALL be PREP_A (present first address), PREP_Q (capture RB1_Q into shifter), SEND (21 cycles), GAP (1 cycle), DONE.
REQ-012 Transitions SHALL be: reset->PREP_A->PREP_Q->SEND; SEND->GAP after bit 21; GAP->SEND if packets sent <8, else GAP->DONE; DONE holds until reset.
REQ-013 sen SHALL be 1 exactly in SEND cycles and 0 in PREP_A, PREP_Q, GAP and DONE.
REQ-014 sd SHALL be 0 whenever sen=0.
REQ-015 Packet SHALL be loaded into a 21-bit shift register as {addr[2:0], data[17:0]}, with sd = shifter MSB and a left shift each SEND cycle.
REQ-016 During SEND, RB1_A SHALL hold the next packet's address, and the block SHALL capture RB1_Q into an 18-bit prefetch buffer on SEND bit 2, ahead of the data phase.
REQ-017 In GAP, the shifter SHALL load {next addr, prefetch buffer}, so packets are spaced exactly 22 cycles (21 sen=1 + 1 sen=0).
REQ-018 A 5-bit bit counter SHALL count 0..20 within SEND, and a 4-bit packet counter SHALL count 0..8, with no wrap-around past 8.
REQ-019 Word addresses SHALL advance modulo 8 from the start address; RB1_A SHALL hold the last address once DONE is reached.
REQ-020 S1_done SHALL assert on the first cycle of DONE and stay 1 until reset.
REQ-021 Total latency SHALL be: first sen=1 on cycle 2 after reset release; S1_done=1 on cycle 2+8*22 = 178.
REQ-022 Changes on RB1_Q outside its capture cycles SHALL have no effect.

Reset
REQ-023 While rst=0, the block SHALL be in PREP_A with sen=0, sd=0, S1_done=0, RB1_RW=1, RB1_A=start address, and all counters, shifter and buffer at 0.
REQ-024 Reset asserted mid-packet SHALL abort the packet on the next clock edge, with no remaining bits sent, and transmission restarts from the start address.

Configuration
REQ-025 Macro S1_REVERSE_ORDER_EN: if defined, start address = 7 and addresses step down (7..0); if not defined, start address = 0 and addresses step up (0..7).
REQ-026 Packet format, timing and S1_done behaviour SHALL be identical in both builds.

Verification
REQ-027 RB1 word n = 18'h20000+n, default build -> packet 0 sd stream = 000 then 10_0000_0000_0000_0000; packet 7 address bits = 111; sen low exactly 1 cycle between packets.
REQ-028 Count cycles from reset release -> sen first high at cycle 2; S1_done rises at cycle 178 and stays high for 50 further cycles; sen stays 0.
REQ-029 RB1 word n = 18'h3FFFF^n -> reconstructed address/data pairs from the serial stream match all 8 words exactly.
REQ-030 Assert rst=0 at bit 10 of packet 3, hold 2 cycles, then release -> sen drops on the next edge and the stream restarts with address 000 (101 in reversed build's first packet is 111).
REQ-031 Build with S1_REVERSE_ORDER_EN -> packet address sequence 7,6,...,0 and data matches RB1[addr]; S1_done at cycle 178.
REQ-032 Check RB1_RW every cycle -> always 1; sd=0 in every cycle where sen=0.

Source files
------------

// File: rtl/rb_serializer.sv
// rtl/rb_serializer.sv - register-bank reader and 21-bit packet serializer
//
// Reads all 8 words of register bank RB1 and sends each word as one 21-bit
// serial packet, {addr[2:0], data[17:0]}, MSB first. Packets are spaced 22
// cycles apart: 21 cycles with sen=1, then 1 gap cycle. After the eighth
// packet the block parks in DONE with S1_done=1 until reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   RB1_RW   out  register-bank read/write select, tied to 1 (read)
//   RB1_A    out  [2:0]  register-bank word address
//   RB1_Q    in   [17:0] register-bank read data, valid one cycle after RB1_A
//   sen      out  serial enable, 1 for every packet bit
//   sd       out  serial data, forced to 0 whenever sen=0
//   S1_done  out  high once all 8 packets are sent
//
// Build option:
//   S1_REVERSE_ORDER_EN  when defined, words are sent 7,6,...,0;
//                        otherwise 0,1,...,7. Timing is the same in both.

module rb_serializer (
    input  logic        clk,
    input  logic        rst,
    output logic        RB1_RW,
    output logic [2:0]  RB1_A,
    input  logic [17:0] RB1_Q,
    output logic        sen,
    output logic        sd,
    output logic        S1_done
);

`ifdef S1_REVERSE_ORDER_EN
    localparam logic [2:0] START_ADDR = 3'd7;
    localparam logic       ADDR_DOWN  = 1'b1;
`else
    localparam logic [2:0] START_ADDR = 3'd0;
    localparam logic       ADDR_DOWN  = 1'b0;
`endif

    localparam logic [4:0] LAST_BIT  = 5'd20;
    localparam logic [4:0] PREF_BIT  = 5'd1;   // second SEND cycle: RB1_Q holds the next word
    localparam logic [3:0] NUM_PKTS  = 4'd8;
    localparam logic [3:0] LAST_PKT  = 4'd7;

    typedef enum logic [2:0] {
        PREP_A,
        PREP_Q,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  pkt_cnt_q, pkt_cnt_d;
    logic [2:0]  addr_q,    addr_d;
    logic [20:0] shift_q,   shift_d;
    logic [17:0] pref_q,    pref_d;

    function automatic logic [2:0] step_addr(input logic [2:0] a);
        return ADDR_DOWN ? (a - 3'd1) : (a + 3'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= PREP_A;
            bit_cnt_q <= '0;
            pkt_cnt_q <= '0;
            addr_q    <= START_ADDR;
            shift_q   <= '0;
            pref_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            pref_q    <= pref_d;
        end
    end

    // addr_q is always the address on RB1_A. Once a packet is loaded into
    // the shifter, addr_q moves on to the following word so its data can be
    // prefetched while the current packet is still shifting out.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        pref_d    = pref_q;

        unique case (state_q)
            PREP_A: begin
                state_d = PREP_Q;
            end

            PREP_Q: begin
                shift_d   = {addr_q, RB1_Q};
                addr_d    = step_addr(addr_q);
                bit_cnt_d = '0;
                state_d   = SEND;
            end

            SEND: begin
                shift_d = {shift_q[19:0], 1'b0};
                if (bit_cnt_q == PREF_BIT) begin
                    pref_d = RB1_Q;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (pkt_cnt_q < NUM_PKTS) begin
                        pkt_cnt_d = pkt_cnt_q + 4'd1;
                    end
                    state_d = GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end

            GAP: begin
                if (pkt_cnt_q < NUM_PKTS) begin
                    shift_d = {addr_q, pref_q};
                    // The last packet's address stays on RB1_A into DONE.
                    if (pkt_cnt_q < LAST_PKT) begin
                        addr_d = step_addr(addr_q);
                    end
                    state_d = SEND;
                end else begin
                    shift_d = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = PREP_A;
            end
        endcase
    end

    assign RB1_RW  = 1'b1;
    assign RB1_A   = addr_q;
    assign sen     = (state_q == SEND);
    assign sd      = sen & shift_q[20];
    assign S1_done = (state_q == DONE);

endmodule

// File: tb/tb_rb_serializer.sv
// tb/tb_rb_serializer.sv - scoreboard bench for rb_serializer

module tb_rb_serializer;

`ifdef S1_REVERSE_ORDER_EN
    localparam logic [2:0] START_ADDR = 3'd7;
    localparam logic [2:0] LAST_ADDR  = 3'd0;
    localparam bit         ADDR_DOWN  = 1'b1;
`else
    localparam logic [2:0] START_ADDR = 3'd0;
    localparam logic [2:0] LAST_ADDR  = 3'd7;
    localparam bit         ADDR_DOWN  = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        RB1_RW;
    logic [2:0]  RB1_A;
    logic [17:0] RB1_Q;
    logic        sen;
    logic        sd;
    logic        S1_done;

    rb_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_Q   (RB1_Q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] mem [8];

    // Register bank: read data appears the cycle after the address.
    always @(posedge clk) RB1_Q <= mem[RB1_A];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [20:0] exp_q [$];

    // Monitor state
    int          cyc;
    int          nbits;
    logic [20:0] pkt_sh;
    int          first_sen;
    int          done_cyc;
    bit          prev_sen;
    int          low_run;
    int          pkts_seen;
    int          rw_bad = 0;
    int          sd_bad;
    int          done_drop;
    int          sen_after_done;

    task automatic mon_clear();
        cyc            = 0;
        nbits          = 0;
        pkt_sh         = '0;
        first_sen      = -1;
        done_cyc       = -1;
        prev_sen       = 1'b0;
        low_run        = 0;
        pkts_seen      = 0;
        sd_bad         = 0;
        done_drop      = 0;
        sen_after_done = 0;
    endtask

    always @(negedge clk) begin
        if (RB1_RW !== 1'b1) rw_bad++;
        if (rst === 1'b1) begin
            cyc++;
            if (!sen && sd) sd_bad++;
            if (sen) begin
                if (first_sen < 0) first_sen = cyc;
                if (!prev_sen && pkts_seen > 0) chk("gap_len", low_run, 1);
                low_run = 0;
                pkt_sh  = {pkt_sh[19:0], sd};
                nbits++;
                if (nbits == 21) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        chk($sformatf("pkt%0d", pkts_seen), pkt_sh, exp_q.pop_front());
                    end
                    pkts_seen++;
                    nbits = 0;
                end
            end else begin
                low_run++;
            end
            if (S1_done) begin
                if (done_cyc < 0) done_cyc = cyc;
                if (sen) sen_after_done++;
            end else if (done_cyc >= 0) begin
                done_drop++;
            end
            prev_sen = sen;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected();
        logic [2:0] a;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            a = ADDR_DOWN ? (START_ADDR - 3'(k)) : (START_ADDR + 3'(k));
            exp_q.push_back({a, mem[a]});
        end
    endtask

    task automatic release_reset();
        push_expected();
        mon_clear();
        rst = 1'b1;
    endtask

    task automatic run_full(input string tag);
        release_reset();
        for (int i = 0; i < 400 && done_cyc < 0; i++) tick();
        repeat (50) tick();
        chk({tag, "_first_sen"}, first_sen, 2);
        chk({tag, "_done_cyc"}, done_cyc, 178);
        chk({tag, "_pkts"}, pkts_seen, 8);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_done_hold"}, done_drop, 0);
        chk({tag, "_sen_after_done"}, sen_after_done, 0);
        chk({tag, "_sd_idle"}, sd_bad, 0);
        chk({tag, "_last_addr"}, RB1_A, LAST_ADDR);
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        for (int n = 0; n < 8; n++) mem[n] = 18'h20000 + 18'(n);
        mon_clear();
        repeat (3) tick();
        chk("rst_sen", sen, 0);
        chk("rst_sd", sd, 0);
        chk("rst_done", S1_done, 0);
        chk("rst_addr", RB1_A, START_ADDR);

        run_full("inc");

        for (int n = 0; n < 8; n++) mem[n] = 18'h3FFFF ^ 18'(n);
        run_full("xor");

        // Abort at bit 10 of packet 3 (cycle 68 + 9), then restart.
        for (int n = 0; n < 8; n++) mem[n] = 18'($urandom);
        release_reset();
        for (int i = 0; i < 200 && cyc < 77; i++) tick();
        chk("abort_cyc", cyc, 77);
        chk("abort_pkts_before", pkts_seen, 3);
        chk("abort_bits_before", nbits, 10);
        chk("abort_sen_before", sen, 1);
        rst = 1'b0;
        tick();
        chk("abort_sen_drop", sen, 0);
        chk("abort_sd_drop", sd, 0);
        chk("abort_addr", RB1_A, START_ADDR);
        tick();
        for (int n = 0; n < 8; n++) mem[n] = 18'($urandom);
        run_full("restart");

        chk("rw_always_read", rw_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
